// File: rtl/cpu_step_pkg.sv
// Shared state encoding, default parameters and sizing helper for the CPU step controller.
package cpu_step_pkg;

    localparam int CPU_CLOCK_DEF       = 27_000_000;
    localparam int DEBOUNCE_CYCLES_DEF = CPU_CLOCK_DEF / 100;
    localparam int CNT_W_DEF           = 16;

    typedef enum logic [1:0] {
        ST_HALT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STEP_WAIT = 2'd2
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button -> 2-FF synchronizer -> debounced level -> one-cycle press pulse on 0->1.
// press_o rises DEBOUNCE_CYCLES+2 edges after a clean press; releases produce nothing.
module button_debounce
    import cpu_step_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int              DW   = cnt_bits(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]   LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stable_q;
    logic          stable_d;
    logic          press_q;
    logic          press_d;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    // Any cycle where synced agrees with stable restarts the qualification window.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        press_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= btn_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Turns divider tick rises into single-cycle CPU clock enables under run/halt/single-step control.
// cpu_en is registered one edge after the synchronized tick rise is seen; no backpressure.
module cpu_step_ctrl
    import cpu_step_pkg::*;
#(
    parameter int CPU_CLOCK       = CPU_CLOCK_DEF,
    parameter int DEBOUNCE_CYCLES = CPU_CLOCK / 100,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic [CNT_W-1:0] step_count
);

    // Reset asserts immediately but releases in step with clk.
    logic [1:0] rst_sync_q;
    logic       rst_core_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    logic run_press;
    logic step_press;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_btn (
        .clk     (clk),
        .rst_n   (rst_core_n),
        .btn_i   (btn_run),
        .press_o (run_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_btn (
        .clk     (clk),
        .rst_n   (rst_core_n),
        .btn_i   (btn_step),
        .press_o (step_press)
    );

    logic tick_s1_q;
    logic tick_s2_q;
    logic tick_prev_q;
    logic tick_rise;

    assign tick_rise = tick_s2_q & ~tick_prev_q;

    state_e             state_q;
    state_e             state_d;
    logic               cpu_en_q;
    logic               cpu_en_d;
    logic               running_q;
    logic [CNT_W-1:0]   step_cnt_q;
    logic [CNT_W-1:0]   step_cnt_d;

    // Halt and run-toggle outrank a coincident tick rise.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (run_press) begin
                    state_d = ST_RUN;
                end else if (step_press) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_RUN: begin
                if (halt_req || run_press) begin
                    state_d = ST_HALT;
                end else begin
                    cpu_en_d = tick_rise;
                end
            end
            ST_STEP_WAIT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (run_press) begin
                    state_d = ST_RUN;
                end else if (tick_rise) begin
                    cpu_en_d = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (cpu_en_q) begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_core_n) begin
        if (!rst_core_n) begin
            tick_s1_q   <= 1'b0;
            tick_s2_q   <= 1'b0;
            tick_prev_q <= 1'b0;
            state_q     <= ST_HALT;
            cpu_en_q    <= 1'b0;
            running_q   <= 1'b0;
            step_cnt_q  <= '0;
        end else begin
            tick_s1_q   <= tick;
            tick_s2_q   <= tick_s1_q;
            tick_prev_q <= tick_s2_q;
            state_q     <= state_d;
            cpu_en_q    <= cpu_en_d;
            running_q   <= (state_d == ST_RUN);
            step_cnt_q  <= step_cnt_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign running    = running_q;
    assign step_count = step_cnt_q;

endmodule
